// File: rtl/sng_lfsr_stream.sv
// Binary-to-stochastic encoder: streams bit = (value > LFSR) for a requested
// number of beats, with valid/ready on both sides and a self-check ones count.
module sng_lfsr_stream #(
    parameter int                DATAWD = 8,
    parameter logic [DATAWD-1:0] SEED   = 8'hFE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATAWD-1:0] in_data,
    input  logic [DATAWD-1:0] in_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_last,
    output logic [DATAWD-1:0] ones_cnt,
    output logic              done
);

    localparam logic [0:0]        IDLE    = 1'b0;
    localparam logic [0:0]        RUN     = 1'b1;
    localparam logic [DATAWD-1:0] LEN_MAX = '1;

    // Maximal-length (255) Fibonacci taps; only meaningful for DATAWD == 8.
    function automatic logic [DATAWD-1:0] lfsr_step(input logic [DATAWD-1:0] s);
        return {s[DATAWD-2:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    logic [0:0]        state_q, state_d;
    logic [DATAWD-1:0] data_q,  data_d;
    logic [DATAWD-1:0] len_q,   len_d;
    logic [DATAWD-1:0] cnt_q,   cnt_d;
    logic [DATAWD-1:0] lfsr_q,  lfsr_d;
    logic [DATAWD-1:0] ones_q,  ones_d;
    logic              done_q,  done_d;
    logic              bit_w;
    logic              last_w;

    // Outputs derive from registers only, so a stall holds them stable.
    assign bit_w     = (state_q == RUN) && (data_q > lfsr_q);
    assign last_w    = (state_q == RUN) && (cnt_q == (len_q - 1'b1));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RUN);
    assign out_bit   = bit_w;
    assign out_last  = last_w;
    assign ones_cnt  = ones_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    len_d   = (in_len == '0) ? LEN_MAX : in_len;
                    lfsr_d  = SEED;
                    cnt_d   = '0;
                    ones_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    lfsr_d = lfsr_step(lfsr_q);
                    cnt_d  = cnt_q + 1'b1;
                    ones_d = ones_q + {{(DATAWD-1){1'b0}}, bit_w};
                    if (last_w) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            lfsr_q  <= SEED;
            ones_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_sng_lfsr_stream.sv
// Bench for sng_lfsr_stream: directed and random streams compared beat by beat
// against a reference model of the encoder.
module tb_sng_lfsr_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [7:0] in_len = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_bit;
    logic       out_last;
    logic [7:0] ones_cnt;
    logic       done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sng_lfsr_stream #(.DATAWD(8), .SEED(8'hFE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .ones_cnt  (ones_cnt),
        .done      (done)
    );

    function automatic int lfsr_next(input int s);
        int fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((s * 2) % 256) + fb;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic accept(input logic [7:0] d, input logic [7:0] l);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        check("accept_ready", {31'b0, in_ready}, 1);
        @(negedge clk);
    endtask

    // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1,0,1 then 1.
    task automatic stream(input logic [7:0] d, input logic [7:0] l, input int mode,
                          input int abort_at, input bit hold_next,
                          input logic [7:0] nd, input logic [7:0] nl);
        int n, idx, cyc, ones, s, limit;
        bit rdy, exp_bit;
        bit pat [6];
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        n     = (l == 0) ? 255 : int'(l);
        idx   = 0;
        cyc   = 0;
        ones  = 0;
        s     = 'hFE;
        limit = 8 * n + 50;
        if (hold_next) begin
            in_valid = 1'b1;
            in_data  = nd;
            in_len   = nl;
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_len   = 8'($urandom);
        end
        while (idx < n && cyc < limit) begin
            if (abort_at != 0 && idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_out_valid", {31'b0, out_valid}, 0);
                check("rst_in_ready",  {31'b0, in_ready}, 1);
                check("rst_out_bit",   {31'b0, out_bit}, 0);
                check("rst_out_last",  {31'b0, out_last}, 0);
                check("rst_ones",      {24'b0, ones_cnt}, 0);
                check("rst_done",      {31'b0, done}, 0);
                @(negedge clk);
                rst_n = 1'b1;
                check("rst_hold_done", {31'b0, done}, 0);
                @(negedge clk);
                check("post_rst_ready", {31'b0, in_ready}, 1);
                check("post_rst_valid", {31'b0, out_valid}, 0);
                check("post_rst_done",  {31'b0, done}, 0);
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc < 6) ? pat[cyc] : 1'b1;
            endcase
            out_ready = rdy;
            exp_bit   = (int'(d) > s);
            check("out_valid",    {31'b0, out_valid}, 1);
            check("in_ready_run", {31'b0, in_ready}, 0);
            check("out_bit",      {31'b0, out_bit}, {31'b0, exp_bit});
            check("out_last",     {31'b0, out_last}, (idx == n - 1) ? 1 : 0);
            check("ones_run",     {24'b0, ones_cnt}, ones);
            check("done_run",     {31'b0, done}, 0);
            if (rdy) begin
                ones += int'(exp_bit);
                s    = lfsr_next(s);
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        check("beats_taken", idx, n);
        out_ready = 1'($urandom_range(0, 1));
        check("done_pulse",  {31'b0, done}, 1);
        check("idle_ready",  {31'b0, in_ready}, 1);
        check("idle_valid",  {31'b0, out_valid}, 0);
        check("ones_final",  {24'b0, ones_cnt}, ones);
        if (l == 0)
            check("ones_formula", {24'b0, ones_cnt}, (d == 0) ? 0 : int'(d) - 1);
        @(negedge clk);
        if (hold_next) begin
            check("b2b_valid", {31'b0, out_valid}, 1);
            check("b2b_ones",  {24'b0, ones_cnt}, 0);
            check("b2b_done",  {31'b0, done}, 0);
        end else begin
            check("done_once", {31'b0, done}, 0);
            check("ones_hold", {24'b0, ones_cnt}, ones);
        end
    endtask

    initial begin
        logic [7:0] rd, rl;
        repeat (3) @(negedge clk);
        check("reset_in_ready",  {31'b0, in_ready}, 1);
        check("reset_out_valid", {31'b0, out_valid}, 0);
        check("reset_out_bit",   {31'b0, out_bit}, 0);
        check("reset_out_last",  {31'b0, out_last}, 0);
        check("reset_ones",      {24'b0, ones_cnt}, 0);
        check("reset_done",      {31'b0, done}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        accept(8'h80, 8'd0);
        stream(8'h80, 8'd0, 0, 0, 1'b0, 8'h00, 8'h00);

        accept(8'hFF, 8'd2);
        stream(8'hFF, 8'd2, 0, 0, 1'b0, 8'h00, 8'h00);

        accept(8'h00, 8'd0);
        stream(8'h00, 8'd0, 0, 0, 1'b0, 8'h00, 8'h00);

        // Stalled 3-bit stream, next request held valid throughout, then len=1.
        accept(8'hFD, 8'd3);
        stream(8'hFD, 8'd3, 2, 0, 1'b1, 8'hFF, 8'd1);
        stream(8'hFF, 8'd1, 0, 0, 1'b0, 8'h00, 8'h00);

        accept(8'h80, 8'd0);
        stream(8'h80, 8'd0, 0, 100, 1'b0, 8'h00, 8'h00);
        accept(8'h80, 8'd0);
        stream(8'h80, 8'd0, 0, 0, 1'b0, 8'h00, 8'h00);

        // Random back-to-back pair.
        rd = 8'($urandom);
        rl = 8'($urandom_range(1, 30));
        accept(8'($urandom), 8'($urandom_range(1, 30)));
        stream(in_data, in_len, 1, 0, 1'b1, rd, rl);
        stream(rd, rl, 1, 0, 1'b0, 8'h00, 8'h00);

        for (int i = 0; i < 10; i++) begin
            rd = 8'($urandom);
            rl = (i == 3) ? 8'd0 : 8'($urandom_range(1, 40));
            accept(rd, rl);
            stream(rd, rl, 1, 0, 1'b0, 8'h00, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
